// File: rtl/data_sync_pkg.sv
// data_sync shared constants and helpers.
// Optional capture counter is enabled with DATA_SYNC_CNT_EN.
package data_sync_pkg;

   localparam int DEF_NUM_STAGES = 2;
   localparam int DEF_BUS_WIDTH  = 8;
   localparam int CNT_WIDTH      = 8;

   function automatic logic rise_det(
      input logic cur,
      input logic prev
   );
      return cur & ~prev;
   endfunction

endpackage

// File: rtl/bit_sync.sv
// Multi-flop level synchroniser, one chain per bit.
// Every flop clears asynchronously on RST low.
module bit_sync #(
   parameter int NUM_STAGES = 2,
   parameter int BUS_WIDTH  = 1
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic [BUS_WIDTH-1:0] ASYNC,
   output logic [BUS_WIDTH-1:0] SYNC
);

   logic [BUS_WIDTH-1:0] stage_q [NUM_STAGES];

   // shift the async level through the flop chain
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         for (int i = 0; i < NUM_STAGES; i++) begin
            stage_q[i] <= '0;
         end
      end else begin
         stage_q[0] <= ASYNC;
         for (int i = 1; i < NUM_STAGES; i++) begin
            stage_q[i] <= stage_q[i-1];
         end
      end
   end

   assign SYNC = stage_q[NUM_STAGES-1];

endmodule

// File: rtl/data_sync.sv
// Bus synchroniser: enable is synchronised, data captured on its rise.
// DATA_SYNC_CNT_EN adds the CAPTURE_CNT output.
module data_sync
   import data_sync_pkg::*;
#(
   parameter int NUM_STAGES = DEF_NUM_STAGES,
   parameter int BUS_WIDTH  = DEF_BUS_WIDTH
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic [BUS_WIDTH-1:0] UNSYNC_BUS,
   input  logic                 BUS_ENABLE,
   output logic [BUS_WIDTH-1:0] SYNC_BUS,
   output logic                 ENABLE_PULSE
`ifdef DATA_SYNC_CNT_EN
   ,
   output logic [CNT_WIDTH-1:0] CAPTURE_CNT
`endif
);

   logic sync_en;
   logic prev_en;
   logic rise;

   bit_sync #(
      .NUM_STAGES (NUM_STAGES),
      .BUS_WIDTH  (1)
   ) u_en_sync (
      .CLK   (CLK),
      .RST   (RST),
      .ASYNC (BUS_ENABLE),
      .SYNC  (sync_en)
   );

   assign rise = rise_det(sync_en, prev_en);

   // remember last synchronised enable for edge detection
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         prev_en <= 1'b0;
      end else begin
         prev_en <= sync_en;
      end
   end

   // data is only sampled once the enable has settled in this domain
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         SYNC_BUS     <= '0;
         ENABLE_PULSE <= 1'b0;
      end else begin
         ENABLE_PULSE <= rise;
         if (rise) begin
            SYNC_BUS <= UNSYNC_BUS;
         end
      end
   end

`ifdef DATA_SYNC_CNT_EN
   // count captures, wrapping naturally at the counter width
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         CAPTURE_CNT <= '0;
      end else if (rise) begin
         CAPTURE_CNT <= CAPTURE_CNT + CNT_WIDTH'(1);
      end
   end
`else
   // no capture counter in this build
`endif

endmodule
